// File: rtl/nn_seq_ctrl.sv
// Sequencer for the 784-32-10 MNIST datapath: walks both layers neuron by neuron,
// drives memory read addresses and MAC strobes, and tracks a running argmax.
//
// state    | meaning
// IDLE     | waiting for start
// L1_MAC   | issue pixel/w1 reads, one product per cycle
// L1_DRAIN | last layer-1 product lands in the accumulator
// L1_WB    | hidden neuron written back through ReLU
// L2_MAC   | issue hidden/w2 reads
// L2_DRAIN | last layer-2 product lands
// L2_CMP   | biased sum compared against the running maximum
// DONE     | predicted valid, done pulse
module nn_seq_ctrl #(
  parameter int N_IN  = 784,
  parameter int N_HID = 32,
  parameter int N_OUT = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [3:0]  predicted,
  output logic        layer,
  output logic [9:0]  x_addr,
  output logic [14:0] w1_addr,
  output logic [4:0]  h_addr,
  output logic [8:0]  w2_addr,
  output logic        acc_clr,
  output logic        acc_en,
  output logic        hid_we,
  output logic [4:0]  hid_waddr,
  input  logic [31:0] acc_in
);

  typedef enum logic [2:0] {
    S_IDLE, S_L1_MAC, S_L1_DRAIN, S_L1_WB,
    S_L2_MAC, S_L2_DRAIN, S_L2_CMP, S_DONE
  } state_t;

  localparam logic [9:0] K1_LAST = 10'(N_IN - 1);
  localparam logic [9:0] K2_LAST = 10'(N_HID - 1);
  localparam logic [4:0] N1_LAST = 5'(N_HID - 1);
  localparam logic [4:0] N2_LAST = 5'(N_OUT - 1);

  state_t             state_q, state_d;
  logic [4:0]         n_q, n_d;
  logic [9:0]         k_q, k_d;
  logic [14:0]        w1_q, w1_d;
  logic [8:0]         w2_q, w2_d;
  logic               acc_clr_q, acc_clr_d;
  logic               acc_en_q, issue;
  logic               hid_we_q, hid_we_d;
  logic               layer_q, layer_d;
  logic               busy_q;
  logic               done_q, done_d;
  logic [3:0]         pred_q, pred_d;
  logic signed [31:0] max_val_q, max_val_d;
  logic [3:0]         max_idx_q, max_idx_d;
  logic               upd;

  assign issue = (state_q == S_L1_MAC) || (state_q == S_L2_MAC);
  // Strict signed compare; n==0 always loads so the reset value of max_val never matters.
  assign upd   = (n_q == 5'd0) || ($signed(acc_in) > max_val_q);

  always_comb begin
    state_d   = state_q;
    n_d       = n_q;
    k_d       = k_q;
    w1_d      = w1_q;
    w2_d      = w2_q;
    acc_clr_d = 1'b0;
    hid_we_d  = 1'b0;
    layer_d   = layer_q;
    done_d    = 1'b0;
    pred_d    = pred_q;
    max_val_d = max_val_q;
    max_idx_d = max_idx_q;
    unique case (state_q)
      S_IDLE: if (start) begin
        state_d   = S_L1_MAC;
        n_d       = '0;
        k_d       = '0;
        w1_d      = '0;
        layer_d   = 1'b0;
        acc_clr_d = 1'b1;
      end
      S_L1_MAC: begin
        if (k_q == K1_LAST) state_d = S_L1_DRAIN;
        else begin
          k_d  = k_q + 10'd1;
          w1_d = w1_q + 15'd1;
        end
      end
      S_L1_DRAIN: begin
        state_d  = S_L1_WB;
        hid_we_d = 1'b1;
      end
      S_L1_WB: begin
        k_d       = '0;
        acc_clr_d = 1'b1;
        if (n_q == N1_LAST) begin
          state_d = S_L2_MAC;
          layer_d = 1'b1;
          n_d     = '0;
          w2_d    = '0;
        end else begin
          state_d = S_L1_MAC;
          n_d     = n_q + 5'd1;
          w1_d    = w1_q + 15'd1;
        end
      end
      S_L2_MAC: begin
        if (k_q == K2_LAST) state_d = S_L2_DRAIN;
        else begin
          k_d  = k_q + 10'd1;
          w2_d = w2_q + 9'd1;
        end
      end
      S_L2_DRAIN: state_d = S_L2_CMP;
      S_L2_CMP: begin
        if (upd) begin
          max_val_d = $signed(acc_in);
          max_idx_d = n_q[3:0];
        end
        if (n_q == N2_LAST) begin
          // Load predicted here so it is valid in the same cycle as done.
          state_d = S_DONE;
          done_d  = 1'b1;
          pred_d  = upd ? n_q[3:0] : max_idx_q;
        end else begin
          state_d   = S_L2_MAC;
          n_d       = n_q + 5'd1;
          k_d       = '0;
          w2_d      = w2_q + 9'd1;
          acc_clr_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        layer_d = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      n_q       <= '0;
      k_q       <= '0;
      w1_q      <= '0;
      w2_q      <= '0;
      acc_clr_q <= 1'b0;
      acc_en_q  <= 1'b0;
      hid_we_q  <= 1'b0;
      layer_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pred_q    <= '0;
      max_val_q <= '0;
      max_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      n_q       <= n_d;
      k_q       <= k_d;
      w1_q      <= w1_d;
      w2_q      <= w2_d;
      acc_clr_q <= acc_clr_d;
      acc_en_q  <= issue;
      hid_we_q  <= hid_we_d;
      layer_q   <= layer_d;
      busy_q    <= (state_d != S_IDLE);
      done_q    <= done_d;
      pred_q    <= pred_d;
      max_val_q <= max_val_d;
      max_idx_q <= max_idx_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign predicted = pred_q;
  assign layer     = layer_q;
  assign x_addr    = k_q;
  assign h_addr    = k_q[4:0];
  assign w1_addr   = w1_q;
  assign w2_addr   = w2_q;
  assign acc_clr   = acc_clr_q;
  assign acc_en    = acc_en_q;
  assign hid_we    = hid_we_q;
  assign hid_waddr = n_q;

endmodule
